// File: rtl/probe_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : probe_frame_pkg
// Description : Shared constants, frame-size helper and state encoding for
//               the probe frame reader (capture-and-readback of the
//               small/quad/wide output vectors as framed 32-bit words).
// Contents    : HDR_MAGIC  - first byte of every frame header
//               calc_nw()  - payload word count, ceil(total/word)
//               state_t    - reader state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package probe_frame_pkg;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    // Number of stream words needed to carry total_w payload bits.
    function automatic int calc_nw(input int total_w, input int word_w);
        return (total_w + word_w - 1) / word_w;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

endpackage : probe_frame_pkg
`default_nettype wire

// File: rtl/probe_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : probe_frame_reader
// Description : Snapshots the small/quad/wide values on a capture request and
//               streams them as one frame: a header word
//               {A5, NW, seq[15:0]} followed by NW payload words taken from
//               P = {pad, in_wide, in_quad, in_small} (in_small at bit 0).
//               Requests arriving while a frame is in flight are dropped and
//               counted, except on the final-word handshake, where they start
//               the next frame back-to-back.
// Ports       : clk, reset          - clock, async active-high reset
//               cap_req             - capture request
//               in_small/quad/wide  - values sampled on an accepted request
//               m_valid/m_ready     - stream handshake
//               m_data, m_last      - stream word, final-word marker
//               busy                - frame in progress
//               ovf_cnt             - saturating dropped-request count
// Revision    : 1.0 - initial release
// ============================================================================
module probe_frame_reader
    import probe_frame_pkg::*;
#(
    parameter int          SMALL_W  = 2,
    parameter int          QUAD_W   = 40,
    parameter int          WIDE_W   = 70,
    parameter int          WORD_W   = 32,
    // Value the frame sequence number takes on reset.
    parameter logic [15:0] SEQ_INIT = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cap_req,
    input  logic [SMALL_W-1:0] in_small,
    input  logic [QUAD_W-1:0]  in_quad,
    input  logic [WIDE_W-1:0]  in_wide,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic [7:0]        ovf_cnt
);

    localparam int TOTAL_W  = SMALL_W + QUAD_W + WIDE_W;
    localparam int NW       = calc_nw(TOTAL_W, WORD_W);
    localparam int SHADOW_W = NW * WORD_W;
    localparam int IDX_W    = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);
    localparam logic [7:0]       NW_BYTE  = 8'(NW);

    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [15:0]         seq_q;
    logic [SHADOW_W-1:0] shadow_q;
    logic [7:0]          ovf_q;
    logic                m_valid_q;
    logic                m_last_q;
    logic [WORD_W-1:0]   m_data_q;
    logic                busy_q;

    logic [SHADOW_W-1:0] payload_d;
    logic [IDX_W-1:0]    idx_d;
    logic                hs;
    logic                last_hs;
    logic                overrun;

    // Zero-extension supplies the pad bits above in_wide.
    assign payload_d = SHADOW_W'({in_wide, in_quad, in_small});
    assign idx_d     = idx_q + IDX_W'(1);
    assign hs        = m_valid_q & m_ready;
    assign last_hs   = hs & (state_q == ST_DATA) & (idx_q == LAST_IDX);
    // The final-word handshake cycle is the one busy cycle that accepts.
    assign overrun   = cap_req & busy_q & ~last_hs;

    function automatic logic [WORD_W-1:0] hdr_word(input logic [15:0] s);
        return WORD_W'({HDR_MAGIC, NW_BYTE, s});
    endfunction

    function automatic logic [WORD_W-1:0] word_at(input logic [IDX_W-1:0] i);
        return shadow_q[32'(i) * WORD_W +: WORD_W];
    endfunction

    // Outputs are loaded one cycle ahead of presentation so that m_data and
    // m_last are plain flops that only change on a handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            seq_q     <= SEQ_INIT;
            shadow_q  <= '0;
            ovf_q     <= 8'h00;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            if (overrun && (ovf_q != 8'hFF)) begin
                ovf_q <= ovf_q + 8'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (cap_req) begin
                        shadow_q  <= payload_d;
                        state_q   <= ST_HDR;
                        m_valid_q <= 1'b1;
                        m_data_q  <= hdr_word(seq_q);
                        m_last_q  <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end

                ST_HDR: begin
                    if (hs) begin
                        state_q  <= ST_DATA;
                        idx_q    <= '0;
                        m_data_q <= word_at('0);
                        m_last_q <= (LAST_IDX == '0);
                    end
                end

                ST_DATA: begin
                    if (hs) begin
                        if (idx_q == LAST_IDX) begin
                            seq_q    <= seq_q + 16'd1;
                            m_last_q <= 1'b0;
                            if (cap_req) begin
                                // Back-to-back: next header carries seq+1.
                                shadow_q <= payload_d;
                                state_q  <= ST_HDR;
                                m_data_q <= hdr_word(seq_q + 16'd1);
                            end else begin
                                state_q   <= ST_IDLE;
                                m_valid_q <= 1'b0;
                                busy_q    <= 1'b0;
                            end
                        end else begin
                            idx_q    <= idx_d;
                            m_data_q <= word_at(idx_d);
                            m_last_q <= (idx_d == LAST_IDX);
                        end
                    end
                end

                default: begin
                    state_q   <= ST_IDLE;
                    m_valid_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign busy    = busy_q;
    assign ovf_cnt = ovf_q;

endmodule : probe_frame_reader
`default_nettype wire

// File: tb/tb_probe_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_probe_frame_reader
// Description : Self-checking bench for probe_frame_reader. Randomized
//               values and backpressure; expected frames come from an
//               arithmetic packing model and are compared word by word
//               against the handshaked stream. A second instance with a
//               near-wrap sequence start covers the 16-bit seq rollover.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_probe_frame_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cap_req = 1'b0;
    logic        cap_req_w = 1'b0;
    logic [1:0]  in_small = '0;
    logic [39:0] in_quad = '0;
    logic [69:0] in_wide = '0;
    logic        m_ready = 1'b0;
    logic        m_ready_w = 1'b1;

    logic        m_valid, m_last, busy;
    logic [31:0] m_data;
    logic [7:0]  ovf_cnt;
    logic        m_valid_w, m_last_w, busy_w;
    logic [31:0] m_data_w;
    logic [7:0]  ovf_cnt_w;

    int checks = 0;
    int errors = 0;
    int ready_pct = 100;
    logic [15:0] m_seq = 16'h0000;
    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];

    probe_frame_reader dut (
        .clk(clk), .reset(reset), .cap_req(cap_req),
        .in_small(in_small), .in_quad(in_quad), .in_wide(in_wide),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .busy(busy), .ovf_cnt(ovf_cnt)
    );

    probe_frame_reader #(.SEQ_INIT(16'hFFFF)) dut_w (
        .clk(clk), .reset(reset), .cap_req(cap_req_w),
        .in_small(in_small), .in_quad(in_quad), .in_wide(in_wide),
        .m_valid(m_valid_w), .m_ready(m_ready_w), .m_data(m_data_w),
        .m_last(m_last_w), .busy(busy_w), .ovf_cnt(ovf_cnt_w)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] hdr(input logic [15:0] s);
        return {8'hA5, 8'd4, s};
    endfunction

    // Expected frame from the current input values: header, then the
    // 112-bit payload split into four 32-bit words, last flag on word 3.
    task automatic model_frame(input logic [15:0] s);
        logic [127:0] p;
        p = 128'(in_small) | (128'(in_quad) << 2) | (128'(in_wide) << 42);
        exp_q.push_back({1'b0, hdr(s)});
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({(k == 3), p[32*k +: 32]});
        end
    endtask

    task automatic rand_inputs();
        logic [63:0] t64;
        logic [95:0] t96;
        t64 = {$urandom, $urandom};
        t96 = {$urandom, $urandom, $urandom};
        in_small = 2'($urandom);
        in_quad  = t64[39:0];
        in_wide  = t96[69:0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        m_ready = ($urandom_range(0, 99) < ready_pct);
    endtask

    // Accept a capture from idle: model the frame, pulse cap_req one cycle.
    task automatic capture();
        cap_req = 1'b1;
        model_frame(m_seq);
        m_seq = m_seq + 16'd1;
        step();
        cap_req = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        if (busy) chk("done_timeout", 64'(busy), 64'(0));
    endtask

    task automatic compare_frames(input string tag);
        int n;
        chk({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_word"}, 64'(got_q[i]), 64'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Stream monitor: record each handshaked word and require a stalled word
    // to be unchanged one cycle later.
    initial begin
        logic        prev_stall;
        logic [33:0] prev_word;
        prev_stall = 1'b0;
        prev_word  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) chk("hold", 64'({m_valid, m_last, m_data}), 64'(prev_word));
                if (m_valid && m_ready) got_q.push_back({m_last, m_data});
                prev_stall = m_valid && !m_ready;
                prev_word  = {m_valid, m_last, m_data};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        step();
        step();
        chk("rst_valid", 64'(m_valid), 64'(0));
        chk("rst_last", 64'(m_last), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_data", 64'(m_data), 64'(0));
        chk("rst_ovf", 64'(ovf_cnt), 64'(0));
        reset = 1'b0;
        step();

        // Basic frame with fixed values and full-rate ready
        ready_pct = 100;
        in_small = 2'b11;
        in_quad  = 40'hAB_CDEF_0123;
        in_wide  = 70'h3F_1234_5678_9ABC_DEF0;
        capture();
        chk("lat_valid", 64'(m_valid), 64'(1));
        chk("lat_hdr", 64'(m_data), 64'(hdr(16'h0000)));
        in_quad = 40'h0;  // later changes must not leak into the frame
        wait_done(50, n);
        chk("busy_drop_cycles", 64'(n), 64'(5));
        compare_frames("basic");

        // Random values under random backpressure
        ready_pct = 70;
        for (int f = 0; f < 8; f++) begin
            rand_inputs();
            capture();
            rand_inputs();
            wait_done(400, n);
            compare_frames("bp");
        end

        // Back-to-back capture on the final-word handshake
        ready_pct = 100;
        step();
        rand_inputs();
        capture();
        n = 0;
        while (!(m_valid && m_last) && n < 20) begin
            step();
            n++;
        end
        chk("b2b_reach_last", 64'(m_valid && m_last), 64'(1));
        rand_inputs();
        cap_req = 1'b1;
        model_frame(m_seq);
        step();
        cap_req = 1'b0;
        chk("b2b_valid", 64'(m_valid), 64'(1));
        chk("b2b_hdr", 64'(m_data), 64'(hdr(m_seq)));
        m_seq = m_seq + 16'd1;
        wait_done(50, n);
        compare_frames("b2b");
        chk("b2b_ovf", 64'(ovf_cnt), 64'(0));

        // Overrun: three dropped requests while stalled
        ready_pct = 0;
        step();
        rand_inputs();
        capture();
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            cap_req = 1'b1;
            step();
            cap_req = 1'b0;
            step();
        end
        chk("ovf_three", 64'(ovf_cnt), 64'(3));
        ready_pct = 100;
        wait_done(50, n);
        compare_frames("ovf");

        // Overrun saturation
        ready_pct = 0;
        step();
        rand_inputs();
        capture();
        for (int i = 0; i < 300; i++) begin
            cap_req = 1'b1;
            step();
            cap_req = 1'b0;
            step();
        end
        chk("ovf_sat", 64'(ovf_cnt), 64'(8'hFF));
        ready_pct = 100;
        wait_done(50, n);
        compare_frames("sat");

        // Reset while payload word 2 is presented
        step();
        rand_inputs();
        capture();
        step();
        step();
        step();
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(m_valid), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_ovf", 64'(ovf_cnt), 64'(0));
        got_q.delete();
        exp_q.delete();
        m_seq = 16'h0000;
        step();
        step();
        reset = 1'b0;
        step();
        rand_inputs();
        capture();
        chk("post_rst_hdr", 64'(m_data), 64'(hdr(16'h0000)));
        wait_done(50, n);
        compare_frames("post_rst");

        // Sequence wrap FFFF -> 0000 on the second instance
        cap_req_w = 1'b1;
        step();
        cap_req_w = 1'b0;
        chk("wrap_hdr_ffff", 64'(m_data_w), 64'(hdr(16'hFFFF)));
        for (int i = 0; i < 4; i++) step();
        chk("wrap_last", 64'(m_last_w), 64'(1));
        cap_req_w = 1'b1;
        step();
        cap_req_w = 1'b0;
        chk("wrap_valid", 64'(m_valid_w), 64'(1));
        chk("wrap_hdr_0000", 64'(m_data_w), 64'(hdr(16'h0000)));
        for (int i = 0; i < 5; i++) step();
        chk("wrap_busy_drop", 64'(busy_w), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_probe_frame_reader
`default_nettype wire
